// File: rtl/spatz_vfu_issue_queue.sv
// In-order issue FIFO between the Spatz controller and a VFU, with an in-flight limit.
// Optional same-cycle bypass of an empty queue: define SPATZ_ISSUE_FALLTHROUGH_EN.
module spatz_vfu_issue_queue #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned REQ_WIDTH    = 128,
    parameter int unsigned MAX_INFLIGHT = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       spatz_req_valid_i,
    output logic                       spatz_req_ready_o,
    input  logic [REQ_WIDTH-1:0]       spatz_req_i,
    output logic                       vfu_req_valid_o,
    input  logic                       vfu_req_ready_i,
    output logic [REQ_WIDTH-1:0]       vfu_req_o,
    input  logic                       vfu_done_i,
    output logic [$clog2(DEPTH):0]     usage_o,
    output logic                       idle_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned UW = PW + 1;
    localparam int unsigned IW = $clog2(MAX_INFLIGHT) + 1;
    localparam logic [UW-1:0] DEPTH_U   = UW'(DEPTH);
    localparam logic [IW-1:0] MAX_INF_I = IW'(MAX_INFLIGHT);

    logic [REQ_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [UW-1:0]        usage_q, usage_d;
    logic [IW-1:0]        inflight_q, inflight_d;

    logic                 empty, can_issue, head_valid, bypass;
    logic                 push, pop, fifo_push, fifo_pop, done_eff;
    logic [REQ_WIDTH-1:0] head_data;

    assign empty     = (usage_q == '0);
    assign can_issue = (inflight_q < MAX_INF_I);

`ifdef SPATZ_ISSUE_FALLTHROUGH_EN
    logic ft_offer;
    assign ft_offer   = empty & spatz_req_valid_i & can_issue;
    assign head_valid = (~empty & can_issue) | ft_offer;
    assign head_data  = empty ? spatz_req_i : mem_q[rd_ptr_q];
    // A bypassed request accepted by the VFU never occupies a FIFO slot.
    assign bypass     = ft_offer & vfu_req_ready_i;
`else
    assign head_valid = ~empty & can_issue;
    assign head_data  = mem_q[rd_ptr_q];
    assign bypass     = 1'b0;
`endif

    // Outputs are masked while rst_i is high so they read as reset values before the first edge.
    assign spatz_req_ready_o = rst_i | (usage_q < DEPTH_U);
    assign vfu_req_valid_o   = ~rst_i & head_valid;
    assign vfu_req_o         = vfu_req_valid_o ? head_data : '0;
    assign usage_o           = rst_i ? '0 : usage_q;
    assign idle_o            = rst_i | (empty & (inflight_q == '0));

    assign push      = spatz_req_valid_i & spatz_req_ready_o;
    assign pop       = vfu_req_valid_o & vfu_req_ready_i;
    assign fifo_push = push & ~bypass;
    assign fifo_pop  = pop & ~empty;
    assign done_eff  = vfu_done_i & (inflight_q != '0);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        usage_d    = usage_q;
        inflight_d = inflight_q;
        if (fifo_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (fifo_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({fifo_push, fifo_pop})
            2'b10:   usage_d = usage_q + UW'(1);
            2'b01:   usage_d = usage_q - UW'(1);
            default: usage_d = usage_q;
        endcase
        case ({pop, done_eff})
            2'b10:   inflight_d = inflight_q + IW'(1);
            2'b01:   inflight_d = inflight_q - IW'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            usage_q    <= '0;
            inflight_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            usage_q    <= usage_d;
            inflight_q <= inflight_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (fifo_push) mem_q[wr_ptr_q] <= spatz_req_i;
    end

endmodule

// File: tb/tb_spatz_vfu_issue_queue.sv
// Scoreboard bench for spatz_vfu_issue_queue: directed scenarios plus random traffic
// checked against a queue-level reference model of occupancy and in-flight count.
module tb_spatz_vfu_issue_queue;

    localparam int DEPTH = 4;
    localparam int REQ_WIDTH = 128;
    localparam int MAX_INFLIGHT = 2;
`ifdef SPATZ_ISSUE_FALLTHROUGH_EN
    localparam bit FT = 1'b1;
`else
    localparam bit FT = 1'b0;
`endif

    logic                 clk;
    logic                 rst;
    logic                 s_valid;
    logic                 s_ready;
    logic [REQ_WIDTH-1:0] s_data;
    logic                 v_valid;
    logic                 v_ready;
    logic [REQ_WIDTH-1:0] v_data;
    logic                 v_done;
    logic [2:0]           usage;
    logic                 idle;

    spatz_vfu_issue_queue #(
        .DEPTH(DEPTH), .REQ_WIDTH(REQ_WIDTH), .MAX_INFLIGHT(MAX_INFLIGHT)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .spatz_req_valid_i(s_valid), .spatz_req_ready_o(s_ready), .spatz_req_i(s_data),
        .vfu_req_valid_o(v_valid), .vfu_req_ready_i(v_ready), .vfu_req_o(v_data),
        .vfu_done_i(v_done), .usage_o(usage), .idle_o(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int m_usage = 0;
    int m_infl = 0;
    logic [REQ_WIDTH-1:0] sb [$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_data(input string name, input logic [REQ_WIDTH-1:0] act,
                            input logic [REQ_WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle of inputs; accepted requests enter the scoreboard in arrival order.
    task automatic drive(input bit v, input bit rdy, input bit dn, input bit rs);
        logic [REQ_WIDTH-1:0] d;
        @(posedge clk);
        #1;
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        rst     = rs;
        s_valid = v;
        s_data  = d;
        v_ready = rdy;
        v_done  = dn;
        if (v && !rs && m_usage < DEPTH) sb.push_back(d);
    endtask

    // Monitor: compares the DUT against the model mid-cycle, then advances the model.
    always @(negedge clk) begin
        bit exp_ready, exp_valid, exp_pop, exp_push, byp;
        int old_usage, old_infl;
        if (rst) begin
            chk("rst_ready", int'(s_ready), 1);
            chk("rst_valid", int'(v_valid), 0);
            chk_data("rst_data", v_data, '0);
            chk("rst_usage", int'(usage), 0);
            chk("rst_idle", int'(idle), 1);
            m_usage = 0;
            m_infl = 0;
            sb.delete();
        end else begin
            old_usage = m_usage;
            old_infl  = m_infl;
            exp_ready = (old_usage < DEPTH);
            exp_valid = (old_usage != 0 && old_infl < MAX_INFLIGHT) ||
                        (FT && old_usage == 0 && s_valid && old_infl < MAX_INFLIGHT);
            chk("ready", int'(s_ready), int'(exp_ready));
            chk("valid", int'(v_valid), int'(exp_valid));
            chk("usage", int'(usage), old_usage);
            chk("idle", int'(idle), int'(old_usage == 0 && old_infl == 0));
            if (v_valid) begin
                if (sb.size() == 0) begin
                    chk("sb_nonempty", 0, 1);
                end else begin
                    chk_data("order", v_data, sb[0]);
                    if (v_ready) void'(sb.pop_front());
                end
            end else begin
                chk_data("idle_data", v_data, '0);
            end
            exp_push = s_valid && exp_ready;
            exp_pop  = exp_valid && v_ready;
            byp      = FT && old_usage == 0 && exp_pop;
            if (exp_push && !byp) m_usage++;
            if (exp_pop && old_usage != 0) m_usage--;
            if (exp_pop) m_infl++;
            if (v_done && old_infl > 0) m_infl--;
        end
    end

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; v_ready = 1'b0; v_done = 1'b0;
        repeat (2) drive(0, 0, 0, 1);

        // Fill A..D with the VFU stalled, then offer E while full.
        repeat (4) drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        // Release: two issue, then the in-flight limit stalls issue.
        repeat (3) drive(0, 1, 0, 0);
        // One completion lets the next entry go; repeat for the last.
        drive(0, 1, 1, 0);
        drive(0, 1, 0, 0);
        drive(0, 1, 1, 0);
        drive(0, 1, 0, 0);
        repeat (2) drive(0, 1, 1, 0);
        // Completion with nothing in flight is ignored.
        repeat (2) drive(0, 0, 1, 0);

        // Two entries, then six cycles of simultaneous push/pop across the wrap.
        repeat (2) drive(1, 0, 0, 0);
        repeat (6) drive(1, 1, 1, 0);
        repeat (6) drive(0, 1, 1, 0);

        // usage=3, inflight=2, then reset discards everything.
        repeat (4) drive(1, 0, 0, 0);
        repeat (2) drive(0, 1, 0, 0);
        drive(1, 0, 0, 0);
        drive(1, 1, 0, 1);
        drive(0, 0, 0, 0);

        // Single push into an empty queue with the VFU ready.
        drive(1, 1, 0, 0);
        repeat (3) drive(0, 1, 1, 0);

        for (int i = 0; i < 500; i++) begin
            drive($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 9) < 3, $urandom_range(0, 99) == 0);
        end

        repeat (20) drive(0, 1, 1, 0);
        @(posedge clk);
        #1;
        chk("drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
